branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, is the number of direct-mapped predictor entries and SHALL be a power of two, 2 or greater.
REQ-002 Parameter ADDR_W, default 32, is the PC and target width.
REQ-003 Parameter STAT_W, default 16, is the width of the statistics counters.
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- lookup_valid  in  1  the IF stage is presenting a fetch PC this cycle.
- lookup_pc  in  ADDR_W  fetch PC.
- pred_taken  out  1  predicted taken.
- pred_target  out  ADDR_W  predicted next PC.
- upd_valid  in  1  a branch was resolved in ID this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual taken target.
- upd_pred_taken  in  1  prediction previously issued for this branch.
- flush_all  in  1  invalidate every entry.
- mispredict  out  1  resolved outcome differs from the issued prediction.
- stat_lookups  out  STAT_W  lookup count.
- stat_mispredicts  out  STAT_W  mispredict count.

Function
REQ-005 IDX_W SHALL be log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
REQ-006 Each entry SHALL hold valid (1 bit), tag, target (ADDR_W bits) and a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-007 Lookup SHALL be combinational with zero latency; hit = valid and tag match at the lookup index.
REQ-008 On hit with counter bit 1 set: pred_taken=1 and pred_target=stored target.
REQ-009 Otherwise: pred_taken=0 and pred_target=lookup_pc+4, modulo 2^ADDR_W.
REQ-010 pred_taken SHALL be 0 whenever lookup_valid=0; pred_target still follows REQ-008/REQ-009.
REQ-011 On upd_valid with a hit at upd_pc:
- counter increments toward 11 if upd_taken, decrements toward 00 if not; it saturates and never wraps.
- target is overwritten with upd_target only when upd_taken=1.
REQ-012 On upd_valid with a miss and upd_taken=1: allocate the entry (valid=1, tag, target=upd_target, counter=10), replacing any prior occupant.
REQ-013 On upd_valid with a miss and upd_taken=0: no state change.
REQ-014 mispredict SHALL equal upd_valid AND (upd_taken XOR upd_pred_taken), combinationally.
REQ-015 stat_lookups SHALL increment on each cycle with lookup_valid=1.
REQ-016 stat_mispredicts SHALL increment on each cycle with mispredict=1.
REQ-017 Both statistics counters SHALL saturate at all-ones.
REQ-018 When lookup and update hit the same index in the same cycle, the lookup SHALL return the pre-update state; there is no bypass.
REQ-019 flush_all=1 SHALL clear every valid bit at the next edge and take priority over a same-cycle update.
REQ-020 flush_all SHALL leave counters, targets and statistics unchanged.

Reset
REQ-021 With rst=0 at a rising edge, the block SHALL:
- clear all valid bits;
- set every counter to 01;
- zero all targets, tags and statistics.
REQ-022 Reset SHALL override flush_all and any update.
REQ-023 While rst=0, outputs SHALL follow REQ-007 to REQ-010 using the reset state, giving pred_taken=0.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight update in that cycle.

Structure
REQ-025 Shared package bp_pkg SHALL hold the counter-state constants (strong-NT, weak-NT, weak-T, strong-T), the allocation value 10 and the reset value 01.
REQ-026 The 2-bit saturating counter update SHALL be a separate sub-module, sat_counter2, with inputs cur and taken and output next.
REQ-027 Entry storage SHALL be flip-flop arrays, not inferred memory, so that reset and flush_all act in one cycle.

Verification
REQ-028 Reset, then lookup_pc=0x100 with lookup_valid=1 -> pred_taken=0, pred_target=0x104, stat_lookups=1 after the edge.
REQ-029 Update pc=0x100, taken=1, target=0x040, pred_taken=0 -> mispredict=1; the next lookup of 0x100 gives pred_taken=1, pred_target=0x040; stat_mispredicts=1.
REQ-030 Counter trajectory at pc=0x100: NT, NT, then T, T, T -> predictions NT, NT, NT, T, and the counter saturates at 11 after the fifth update.
REQ-031 Aliasing with ENTRIES=16: allocate 0x100 taken, then allocate 0x140 taken -> lookup 0x100 misses (pred_target=0x104) and lookup 0x140 hits.
REQ-032 Same-cycle update (allocate, taken) and lookup of 0x200 -> the lookup predicts not-taken; the following cycle predicts taken.
REQ-033 flush_all asserted together with an update to 0x100 -> every entry is invalid next cycle and the statistics are unchanged.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: 2-bit counter states and the
// values written at allocation and at reset.
package bp_pkg;
  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT   = 2'b00;  // strong not-taken
  localparam ctr_t CTR_WNT   = 2'b01;  // weak not-taken
  localparam ctr_t CTR_WT    = 2'b10;  // weak taken
  localparam ctr_t CTR_ST    = 2'b11;  // strong taken

  localparam ctr_t CTR_ALLOC = CTR_WT;   // new entries start weakly taken
  localparam ctr_t CTR_RESET = CTR_WNT;  // cold entries sit weakly not-taken
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state: steps toward strong-T on taken and
// toward strong-NT otherwise, holding at either end.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next
);

  // saturating step in the direction of the outcome
  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != CTR_ST)  next = cur + 2'd1;
    end else begin
      if (cur != CTR_SNT) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters. Lookup is purely
// combinational from the registered entries (no bypass from a same-cycle
// update); updates, flush and reset land on the rising edge.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic              flush_all,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // entry storage kept in flops so reset/flush clear everything in one edge
  logic [ENTRIES-1:0]             r_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  r_tag;
  logic [ENTRIES-1:0][ADDR_W-1:0] r_tgt;
  logic [ENTRIES-1:0][1:0]        r_ctr;
  logic [STAT_W-1:0]              r_stat_lk;
  logic [STAT_W-1:0]              r_stat_mp;

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  logic             w_lk_hit, w_up_hit;
  logic [1:0]       w_ctr_next;
  logic             w_unused;

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = upd_pc[ADDR_W-1:IDX_W+2];
  // byte-offset bits of the update PC carry no information here
  assign w_unused = ^upd_pc[1:0];

  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  sat_counter2 u_ctr (
    .cur   (r_ctr[w_up_idx]),
    .taken (upd_taken),
    .next  (w_ctr_next)
  );

  // lookup: taken only on a hit with the counter's upper bit set
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = lookup_pc + ADDR_W'(4);
    if (w_lk_hit && r_ctr[w_lk_idx][1]) begin
      pred_target = r_tgt[w_lk_idx];
      pred_taken  = lookup_valid;
    end
  end

  assign mispredict       = upd_valid && (upd_taken ^ upd_pred_taken);
  assign stat_lookups     = r_stat_lk;
  assign stat_mispredicts = r_stat_mp;

  // entry update: reset beats flush, flush beats a resolved branch
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_tag   <= '0;
      r_tgt   <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_RESET;
    end else if (flush_all) begin
      r_valid <= '0;
    end else if (upd_valid) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_next;
        if (upd_taken) r_tgt[w_up_idx] <= upd_target;
      end else if (upd_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_tag[w_up_idx]   <= w_up_tag;
        r_tgt[w_up_idx]   <= upd_target;
        r_ctr[w_up_idx]   <= CTR_ALLOC;
      end
    end
  end

  // saturating statistics counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_lk <= '0;
      r_stat_mp <= '0;
    end else begin
      if (lookup_valid && (r_stat_lk != '1)) r_stat_lk <= r_stat_lk + 1'b1;
      if (mispredict   && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench: stimulus computes expected outputs from a table-level
// model and queues them; a negedge monitor pops and compares.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 32;
  localparam int STAT_W  = 4;   // narrow so saturation is reached quickly
  localparam int IDX_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic              flush_all;
  logic              mispredict;
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .flush_all(flush_all), .mispredict(mispredict),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    int          sl;
    int          sm;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // reference model: one record per slot, keyed by full PC
  bit          m_v  [ENTRIES];
  logic [31:0] m_pc [ENTRIES];
  logic [31:0] m_tgt[ENTRIES];
  int          m_ctr[ENTRIES];
  int          m_sl, m_sm;

  function automatic int slot(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction
  function automatic bit same_line(logic [31:0] a, logic [31:0] b);
    return (a >> (2 + IDX_W)) == (b >> (2 + IDX_W));
  endfunction
  function automatic bit m_hit(logic [31:0] pc);
    return m_v[slot(pc)] && same_line(m_pc[slot(pc)], pc);
  endfunction

  task automatic step(input string nm, input bit lv, input logic [31:0] lpc,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt, input bit upt,
                      input bit fl, input bit r, input bit chk);
    exp_t e;
    bit mp;
    int s;
    rst = r; lookup_valid = lv; lookup_pc = lpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utgt; upd_pred_taken = upt; flush_all = fl;
    mp = uv && (ut != upt);
    if (chk) begin
      e.name = nm;
      e.mp   = mp;
      e.sl   = m_sl;
      e.sm   = m_sm;
      if (m_hit(lpc) && m_ctr[slot(lpc)] >= 2) begin
        e.pt = lv; e.ptgt = m_tgt[slot(lpc)];
      end else begin
        e.pt = 1'b0; e.ptgt = lpc + 32'd4;
      end
      q.push_back(e);
    end
    // state after the coming edge
    if (!r) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_v[i] = 0; m_pc[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_sl = 0; m_sm = 0;
    end else begin
      if (fl) begin
        for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
      end else if (uv) begin
        s = slot(upc);
        if (m_hit(upc)) begin
          m_ctr[s] = ut ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                        : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
          if (ut) m_tgt[s] = utgt;
        end else if (ut) begin
          m_v[s] = 1; m_pc[s] = upc; m_tgt[s] = utgt; m_ctr[s] = 2;
        end
      end
      if (lv && m_sl < (1 << STAT_W) - 1) m_sl++;
      if (mp && m_sm < (1 << STAT_W) - 1) m_sm++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string nm, input logic [31:0] pc);
    step(nm, 1, pc, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask
  task automatic upd(input string nm, input logic [31:0] pc, input bit t,
                     input logic [31:0] tgt, input bit pt);
    step(nm, 1, pc, 1, pc, t, tgt, pt, 0, 1, 1);
  endtask

  // monitor: outputs are always presented, compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk += 5;
        if (pred_taken !== e.pt) begin
          n_fail++;
          $display("FAIL %s pred_taken got %0b want %0b", e.name, pred_taken, e.pt);
        end
        if (pred_target !== e.ptgt) begin
          n_fail++;
          $display("FAIL %s pred_target got %h want %h", e.name, pred_target, e.ptgt);
        end
        if (mispredict !== e.mp) begin
          n_fail++;
          $display("FAIL %s mispredict got %0b want %0b", e.name, mispredict, e.mp);
        end
        if (stat_lookups !== STAT_W'(e.sl)) begin
          n_fail++;
          $display("FAIL %s stat_lookups got %0d want %0d", e.name, stat_lookups, e.sl);
        end
        if (stat_mispredicts !== STAT_W'(e.sm)) begin
          n_fail++;
          $display("FAIL %s stat_mispredicts got %0d want %0d", e.name, stat_mispredicts, e.sm);
        end
      end
    end
  end

  initial begin
    logic [31:0] pa, pb, tg;
    bit r;
    // first edge: DUT state unknown before it, so no checks yet
    step("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 32'h100, 1, 32'h100, 1, 32'h40, 0, 1, 0, 1);
    look("reset_lookup", 32'h100);
    look("stat_after_lookup", 32'h100);
    upd("alloc_mispredict", 32'h100, 1, 32'h040, 0);
    look("hit_after_alloc", 32'h100);
    // counter trajectory at 0x100 (starts at weak-T)
    upd("traj_nt1", 32'h100, 0, 32'h0, 1);
    look("traj_l1", 32'h100);
    upd("traj_nt2", 32'h100, 0, 32'h0, 0);
    look("traj_l2", 32'h100);
    upd("traj_t1", 32'h100, 1, 32'h044, 0);
    look("traj_l3", 32'h100);
    upd("traj_t2", 32'h100, 1, 32'h048, 0);
    look("traj_l4", 32'h100);
    upd("traj_t3", 32'h100, 1, 32'h04c, 1);
    upd("traj_t4", 32'h100, 1, 32'h050, 1);
    upd("traj_sat_nt", 32'h100, 0, 32'h0, 1);
    look("traj_after_sat", 32'h100);
    // aliasing 0x100 / 0x140 share slot 0
    upd("alias_alloc", 32'h140, 1, 32'h080, 0);
    look("alias_old_miss", 32'h100);
    look("alias_new_hit", 32'h140);
    // same-cycle allocate and lookup: no bypass
    step("same_cycle", 1, 32'h200, 1, 32'h200, 1, 32'h0c0, 0, 0, 1, 1);
    look("same_cycle_next", 32'h200);
    upd("pre_flush", 32'h104, 1, 32'h300, 1);
    step("flush_upd", 0, 32'h104, 1, 32'h100, 1, 32'h040, 1, 1, 1, 1);
    look("flush_miss_a", 32'h200);
    look("flush_miss_b", 32'h104);
    look("flush_miss_c", 32'h100);
    // lookup_valid low still produces a target
    step("lv_low", 0, 32'hffff_fffc, 0, 0, 0, 0, 0, 0, 1, 1);
    // randomized: small PC pool so hits, aliasing and saturation all occur
    for (int i = 0; i < 600; i++) begin
      pa = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'b00};
      pb = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 15) == 0) pa = 32'hffff_fffc;
      tg = $urandom & 32'hffff_fffc;
      r  = ($urandom_range(0, 79) != 0);
      step("rand", $urandom_range(0, 3) != 0, pa, $urandom_range(0, 2) != 0, pb,
           $urandom_range(0, 1), tg, $urandom_range(0, 1),
           $urandom_range(0, 29) == 0, r, 1);
    end
    step("drain", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue has %0d entries want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
